camera_rd_sync_mux: RTL and testbench

Frame-synchronous read-window selector for the camera-to-display path. It watches the display timing counters and produces the SDRAM read-enable for one of `NUM_WIN` programmable camera windows. Window changes are applied only at frame boundaries, and each change issues an SDRAM-FIFO reset pulse. It replaces the fixed two-window, two-flag synchroniser and sits between the VGA timing generator and the SDRAM read-FIFO controller.

---
 rtl/camera_rd_pkg.sv | 26 ++
 rtl/camera_win_detect.sv | 35 +++
 rtl/camera_rd_sync_mux.sv | 164 ++++++++++++++++
 tb/tb_camera_rd_sync_mux.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_rd_pkg.sv
// Shared types and helpers for the frame-synchronous camera read-window selector.
package camera_rd_pkg;

    localparam int NUM_WIN_DEF = 2;
    localparam int IDX_W       = $clog2(NUM_WIN_DEF);
    localparam int GEO_W       = 12;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_PEND,
        S_RST
    } rd_state_e;

    typedef struct packed {
        logic [GEO_W-1:0] x;
        logic [GEO_W-1:0] y;
        logic [GEO_W-1:0] w;
        logic [GEO_W-1:0] h;
    } win_geo_t;

    function automatic int idx_width(input int n);
        return (n > NUM_WIN_DEF) ? $clog2(n) : IDX_W;
    endfunction

endpackage

// File: rtl/camera_win_detect.sv
// Registered window compare for the active window; end sums carry one extra bit so x+w / y+h never wrap.
module camera_win_detect
    import camera_rd_pkg::*;
#(
    parameter int CNT_W = GEO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] dx,
    input  logic [CNT_W-1:0] dy,
    input  win_geo_t         geo,
    output logic             en
);

    logic [CNT_W:0] x_end;
    logic [CNT_W:0] y_end;
    logic           hit;

    always_comb begin
        x_end = {1'b0, geo.x} + {1'b0, geo.w};
        y_end = {1'b0, geo.y} + {1'b0, geo.h};
        hit   = (dx >= geo.x) && ({1'b0, dx} < x_end) &&
                (dy >= geo.y) && ({1'b0, dy} < y_end);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en <= 1'b0;
        end else begin
            en <= enable && hit;
        end
    end

endmodule

// File: rtl/camera_rd_sync_mux.sv
// Selects one of NUM_WIN camera windows for SDRAM reads; window changes land on frame boundaries
// and each one pulses the read-FIFO reset.
//   state | meaning
//   INIT  | after reset, FIFO held in reset, waiting for first frame end to load window 0
//   RUN   | reading the active window, nothing pending
//   PEND  | still reading the old window, new window loads at frame end
//   RST   | new window loaded, FIFO reset low for RST_LEN clocks
module camera_rd_sync_mux
    import camera_rd_pkg::*;
#(
    parameter int NUM_WIN = NUM_WIN_DEF,
    parameter int CNT_W   = GEO_W,
    parameter int ADDR_W  = 23,
    parameter int H_TOTAL = 1344,
    parameter int V_TOTAL = 806,
    parameter int THB     = 296,
    parameter int TVB     = 35,
    parameter int RST_LEN = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CNT_W-1:0]              hcnt,
    input  logic [CNT_W-1:0]              vcnt,
    input  logic                          sel_req,
    input  logic [idx_width(NUM_WIN)-1:0] sel_idx,
    input  logic                          next_req,
    input  logic [NUM_WIN*CNT_W-1:0]      win_x,
    input  logic [NUM_WIN*CNT_W-1:0]      win_y,
    input  logic [NUM_WIN*CNT_W-1:0]      win_w,
    input  logic [NUM_WIN*CNT_W-1:0]      win_h,
    input  logic [NUM_WIN*ADDR_W-1:0]     win_base,
    output logic                          sdram_rden,
    output logic                          sdram_rst_n,
    output logic [ADDR_W-1:0]             rd_b_addr,
    output logic [ADDR_W-1:0]             rd_e_addr,
    output logic [idx_width(NUM_WIN)-1:0] active_win,
    output logic                          switch_busy
);

    localparam int IW    = idx_width(NUM_WIN);
    localparam int RC_W  = $clog2(RST_LEN + 1);
    localparam int SUM_W = (ADDR_W > 2*CNT_W) ? ADDR_W : 2*CNT_W;
    localparam logic [CNT_W-1:0] H_OFF   = CNT_W'(THB - 1);
    localparam logic [CNT_W-1:0] V_OFF   = CNT_W'(TVB);
    localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RST_LEN - 1);

    rd_state_e         state;
    logic [RC_W-1:0]   rst_cnt;
    logic              pend_valid;
    logic [IW-1:0]     pend_idx;
    win_geo_t          geo;

    logic              frame_tick;
    logic              sel_ok;
    logic              req_ok;
    logic              rd_go;
    logic [IW-1:0]     next_idx;
    logic [IW-1:0]     req_idx;
    logic [IW-1:0]     load_idx;
    int                li;
    win_geo_t          load_geo;
    logic [ADDR_W-1:0] load_base;
    logic [2*CNT_W-1:0] load_area;
    logic [SUM_W-1:0]  load_end;
    logic [CNT_W-1:0]  dx;
    logic [CNT_W-1:0]  dy;

    assign frame_tick = (hcnt == CNT_W'(H_TOTAL - 1)) && (vcnt == CNT_W'(V_TOTAL - 1));
    assign dx = hcnt - H_OFF;
    assign dy = vcnt - V_OFF;

    always_comb begin
        next_idx = (active_win == IW'(NUM_WIN - 1)) ? '0 : active_win + IW'(1);
        // Re-selecting the active window only matters when it cancels a pending switch.
        sel_ok   = sel_req && ({1'b0, sel_idx} < (IW+1)'(NUM_WIN)) &&
                   (pend_valid || (sel_idx != active_win));
        req_ok   = sel_ok || next_req;
        req_idx  = sel_ok ? sel_idx : next_idx;

        load_idx   = (state == S_INIT) ? '0 : pend_idx;
        li         = int'(load_idx);
        load_geo.x = win_x[li*CNT_W +: CNT_W];
        load_geo.y = win_y[li*CNT_W +: CNT_W];
        load_geo.w = win_w[li*CNT_W +: CNT_W];
        load_geo.h = win_h[li*CNT_W +: CNT_W];
        load_base  = win_base[li*ADDR_W +: ADDR_W];
        load_area  = {{CNT_W{1'b0}}, load_geo.w} * {{CNT_W{1'b0}}, load_geo.h};
        load_end   = SUM_W'(load_base) + SUM_W'(load_area);

        // Compare is enabled when the cycle after this one is RUN or PEND.
        rd_go = (state == S_RUN) || ((state == S_PEND) && !frame_tick) ||
                ((state == S_RST) && (rst_cnt == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_INIT;
            rst_cnt     <= '0;
            pend_valid  <= 1'b0;
            pend_idx    <= '0;
            geo         <= '0;
            active_win  <= '0;
            rd_b_addr   <= '0;
            rd_e_addr   <= '0;
            sdram_rst_n <= 1'b0;
            switch_busy <= 1'b1;
        end else begin
            if (req_ok) begin
                pend_valid <= 1'b1;
                pend_idx   <= req_idx;
            end else if ((state == S_PEND) && frame_tick) begin
                pend_valid <= 1'b0;
            end

            case (state)
                S_INIT, S_PEND: begin
                    if (frame_tick) begin
                        geo         <= load_geo;
                        active_win  <= load_idx;
                        rd_b_addr   <= load_base;
                        rd_e_addr   <= load_end[ADDR_W-1:0];
                        rst_cnt     <= RC_LOAD;
                        sdram_rst_n <= 1'b0;
                        switch_busy <= 1'b1;
                        state       <= S_RST;
                    end
                end
                S_RUN: begin
                    if (req_ok) begin
                        switch_busy <= 1'b1;
                        state       <= S_PEND;
                    end
                end
                S_RST: begin
                    if (rst_cnt == '0) begin
                        sdram_rst_n <= 1'b1;
                        if (pend_valid || req_ok) begin
                            state <= S_PEND;
                        end else begin
                            switch_busy <= 1'b0;
                            state       <= S_RUN;
                        end
                    end else begin
                        rst_cnt <= rst_cnt - RC_W'(1);
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    camera_win_detect #(
        .CNT_W(CNT_W)
    ) u_detect (
        .clk    (clk),
        .rst    (rst),
        .enable (rd_go),
        .dx     (dx),
        .dy     (dy),
        .geo    (geo),
        .en     (sdram_rden)
    );

endmodule

// File: tb/tb_camera_rd_sync_mux.sv
// Directed bench for camera_rd_sync_mux on a shrunken 40x30 raster with three windows.
module tb_camera_rd_sync_mux;

    localparam int NW    = 3;
    localparam int CW    = 12;
    localparam int AW    = 23;
    localparam int HT    = 40;
    localparam int VT    = 30;
    localparam int FRAME = HT * VT;

    logic           clk = 1'b0;
    logic           rst;
    logic [CW-1:0]  hcnt;
    logic [CW-1:0]  vcnt;
    logic           sel_req;
    logic [1:0]     sel_idx;
    logic           next_req;
    logic [NW*CW-1:0] win_x, win_y, win_w, win_h;
    logic [NW*AW-1:0] win_base;
    logic           sdram_rden;
    logic           sdram_rst_n;
    logic [AW-1:0]  rd_b_addr;
    logic [AW-1:0]  rd_e_addr;
    logic [1:0]     active_win;
    logic           switch_busy;

    int n_chk  = 0;
    int n_pass = 0;
    bit ticked;

    always #5 clk = ~clk;

    camera_rd_sync_mux #(
        .NUM_WIN(NW), .CNT_W(CW), .ADDR_W(AW), .H_TOTAL(HT), .V_TOTAL(VT),
        .THB(6), .TVB(3), .RST_LEN(16)
    ) dut (
        .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt),
        .sel_req(sel_req), .sel_idx(sel_idx), .next_req(next_req),
        .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h), .win_base(win_base),
        .sdram_rden(sdram_rden), .sdram_rst_n(sdram_rst_n),
        .rd_b_addr(rd_b_addr), .rd_e_addr(rd_e_addr),
        .active_win(active_win), .switch_busy(switch_busy)
    );

    // One clock: outputs afterwards reflect the edge that sampled the previous hcnt/vcnt.
    task automatic step();
        ticked = (hcnt == CW'(HT-1)) && (vcnt == CW'(VT-1));
        @(posedge clk);
        #1;
        sel_req  = 1'b0;
        next_req = 1'b0;
        if (hcnt == CW'(HT-1)) begin
            hcnt = '0;
            vcnt = (vcnt == CW'(VT-1)) ? '0 : vcnt + CW'(1);
        end else begin
            hcnt = hcnt + CW'(1);
        end
    endtask

    task automatic step_n(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic run_to_tick(output int rhi);
        int n = 0;
        rhi = 0;
        ticked = 1'b0;
        while (!ticked && n < 2*FRAME) begin
            if (sdram_rst_n === 1'b1) rhi++;
            step();
            n++;
        end
        n_chk++;
        if (!ticked) $display("FAIL tick_timeout: got no frame_tick within %0d cycles", n);
        else n_pass++;
    endtask

    task automatic frame_stats(output int rd, output int fh, output int fv,
                               output int lo, output int rise, output int bfall);
        int n = 0;
        rd = 0; fh = -1; fv = -1; lo = 0; rise = -1; bfall = -1;
        ticked = 1'b0;
        while (!ticked && n < 2*FRAME) begin
            if (sdram_rden === 1'b1) begin
                if (fh < 0) begin fh = int'(hcnt); fv = int'(vcnt); end
                rd++;
            end
            if (sdram_rst_n !== 1'b1) lo++;
            else if (rise < 0) rise = n;
            if (switch_busy !== 1'b1 && bfall < 0) bfall = n;
            step();
            n++;
        end
        n_chk++;
        if (!ticked) $display("FAIL frame_timeout: got no frame_tick within %0d cycles", n);
        else n_pass++;
    endtask

    task automatic test_reset();
        int rd, fh, fv, lo, rise, bf;
        rst = 1'b1;
        step_n(3);
        n_chk++; if (sdram_rden !== 1'b0) $display("FAIL rst_rden: got %b want 0", sdram_rden); else n_pass++;
        n_chk++; if (sdram_rst_n !== 1'b0) $display("FAIL rst_rst_n: got %b want 0", sdram_rst_n); else n_pass++;
        n_chk++; if (rd_b_addr !== '0) $display("FAIL rst_b_addr: got %0h want 0", rd_b_addr); else n_pass++;
        n_chk++; if (rd_e_addr !== '0) $display("FAIL rst_e_addr: got %0h want 0", rd_e_addr); else n_pass++;
        n_chk++; if (active_win !== 2'd0) $display("FAIL rst_active: got %0d want 0", active_win); else n_pass++;
        n_chk++; if (switch_busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", switch_busy); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_init_release();
        int rhi, rd, fh, fv, lo, rise, bf;
        run_to_tick(rhi);
        n_chk++; if (rhi !== 0) $display("FAIL init_rst_n_high: got %0d cycles want 0", rhi); else n_pass++;
        n_chk++; if (rd_e_addr !== 23'd40) $display("FAIL init_e_addr: got %0d want 40", rd_e_addr); else n_pass++;
        n_chk++; if (sdram_rst_n !== 1'b0) $display("FAIL init_pulse: got %b want 0", sdram_rst_n); else n_pass++;
        frame_stats(rd, fh, fv, lo, rise, bf);
        n_chk++; if (rise !== 16) $display("FAIL init_rise: got %0d want 16", rise); else n_pass++;
        n_chk++; if (bf !== 16) $display("FAIL init_busy_fall: got %0d want 16", bf); else n_pass++;
        n_chk++; if (rd !== 40) $display("FAIL init_rd_cnt0: got %0d want 40", rd); else n_pass++;
        frame_stats(rd, fh, fv, lo, rise, bf);
        n_chk++; if (rd !== 40) $display("FAIL init_rd_cnt1: got %0d want 40", rd); else n_pass++;
        n_chk++; if (fh !== 6 || fv !== 3) $display("FAIL init_first: got h%0d v%0d want h6 v3", fh, fv); else n_pass++;
        n_chk++; if (lo !== 0) $display("FAIL init_no_pulse: got %0d low cycles want 0", lo); else n_pass++;
    endtask

    task automatic test_next_req();
        int rhi, rd, fh, fv, lo, rise, bf;
        step_n(200);
        next_req = 1'b1;
        step();
        n_chk++; if (switch_busy !== 1'b1) $display("FAIL next_busy: got %b want 1", switch_busy); else n_pass++;
        n_chk++; if (sdram_rst_n !== 1'b1 || active_win !== 2'd0)
            $display("FAIL next_early: got rst_n %b win %0d want 1 0", sdram_rst_n, active_win); else n_pass++;
        run_to_tick(rhi);
        n_chk++; if (active_win !== 2'd1) $display("FAIL next_active: got %0d want 1", active_win); else n_pass++;
        n_chk++; if (rd_b_addr !== 23'h10000) $display("FAIL next_b_addr: got %0h want 10000", rd_b_addr); else n_pass++;
        n_chk++; if (rd_e_addr !== 23'h1003C) $display("FAIL next_e_addr: got %0h want 1003c", rd_e_addr); else n_pass++;
        frame_stats(rd, fh, fv, lo, rise, bf);
        n_chk++; if (rd !== 60) $display("FAIL next_rd_cnt: got %0d want 60", rd); else n_pass++;
        n_chk++; if (fh !== 10 || fv !== 5) $display("FAIL next_first: got h%0d v%0d want h10 v5", fh, fv); else n_pass++;
        n_chk++; if (rise !== 16 || bf !== 16) $display("FAIL next_rise: got rise %0d busy %0d want 16 16", rise, bf); else n_pass++;
    endtask

    task automatic test_wrap();
        int rhi, rd, fh, fv, lo, rise, bf;
        step_n(100);
        next_req = 1'b1;
        step();
        run_to_tick(rhi);
        n_chk++; if (active_win !== 2'd2) $display("FAIL wrap_active2: got %0d want 2", active_win); else n_pass++;
        n_chk++; if (rd_e_addr !== 23'h2000C) $display("FAIL wrap_e_addr2: got %0h want 2000c", rd_e_addr); else n_pass++;
        frame_stats(rd, fh, fv, lo, rise, bf);
        n_chk++; if (rd !== 12 || fh !== 8 || fv !== 4)
            $display("FAIL wrap_rd2: got cnt %0d h%0d v%0d want 12 h8 v4", rd, fh, fv); else n_pass++;
        n_chk++; if (lo !== 16) $display("FAIL wrap_pulse2: got %0d want 16", lo); else n_pass++;
        step_n(100);
        next_req = 1'b1;
        step();
        run_to_tick(rhi);
        n_chk++; if (active_win !== 2'd0) $display("FAIL wrap_active0: got %0d want 0", active_win); else n_pass++;
        n_chk++; if (rd_e_addr !== 23'd40) $display("FAIL wrap_e_addr0: got %0h want 28", rd_e_addr); else n_pass++;
        frame_stats(rd, fh, fv, lo, rise, bf);
        n_chk++; if (lo !== 16) $display("FAIL wrap_pulse0: got %0d want 16", lo); else n_pass++;
    endtask

    task automatic test_ignored();
        int rhi;
        step_n(100);
        sel_req = 1'b1; sel_idx = 2'd0;
        step();
        n_chk++; if (switch_busy !== 1'b0) $display("FAIL ign_same_busy: got %b want 0", switch_busy); else n_pass++;
        sel_req = 1'b1; sel_idx = 2'd3;
        step();
        n_chk++; if (switch_busy !== 1'b0) $display("FAIL ign_range_busy: got %b want 0", switch_busy); else n_pass++;
        run_to_tick(rhi);
        n_chk++; if (sdram_rst_n !== 1'b1 || active_win !== 2'd0)
            $display("FAIL ign_no_switch: got rst_n %b win %0d want 1 0", sdram_rst_n, active_win); else n_pass++;
    endtask

    task automatic test_priority();
        int rhi, rd, fh, fv, lo, rise, bf;
        step_n(100);
        sel_req = 1'b1; sel_idx = 2'd2; next_req = 1'b1;
        step();
        run_to_tick(rhi);
        n_chk++; if (active_win !== 2'd2) $display("FAIL prio_sel_wins: got %0d want 2", active_win); else n_pass++;
        frame_stats(rd, fh, fv, lo, rise, bf);
        step_n(100);
        next_req = 1'b1;
        step();
        run_to_tick(rhi);
        n_chk++; if (active_win !== 2'd0) $display("FAIL prio_wrap: got %0d want 0", active_win); else n_pass++;
        frame_stats(rd, fh, fv, lo, rise, bf);
        step_n(100);
        sel_req = 1'b1; sel_idx = 2'd1;
        step();
        step_n(10);
        sel_req = 1'b1; sel_idx = 2'd0;
        step();
        n_chk++; if (switch_busy !== 1'b1) $display("FAIL prio_overwrite_busy: got %b want 1", switch_busy); else n_pass++;
        run_to_tick(rhi);
        n_chk++; if (sdram_rst_n !== 1'b0 || active_win !== 2'd0 || rd_e_addr !== 23'd40)
            $display("FAIL prio_overwrite: got rst_n %b win %0d e %0d want 0 0 40", sdram_rst_n, active_win, rd_e_addr);
        else n_pass++;
        frame_stats(rd, fh, fv, lo, rise, bf);
        n_chk++; if (rise !== 16 || rd !== 40) $display("FAIL prio_frame: got rise %0d cnt %0d want 16 40", rise, rd); else n_pass++;
    endtask

    task automatic test_req_at_tick();
        int rhi, rd, fh, fv, lo, rise, bf;
        int n = 0;
        while (!(hcnt == CW'(HT-1) && vcnt == CW'(VT-1)) && n < 2*FRAME) begin
            step();
            n++;
        end
        n_chk++; if (n >= 2*FRAME) $display("FAIL tick_seek: got %0d cycles without reaching frame end", n); else n_pass++;
        next_req = 1'b1;
        step();
        n_chk++; if (active_win !== 2'd0 || sdram_rst_n !== 1'b1 || switch_busy !== 1'b1)
            $display("FAIL attick_defer: got win %0d rst_n %b busy %b want 0 1 1", active_win, sdram_rst_n, switch_busy);
        else n_pass++;
        run_to_tick(rhi);
        n_chk++; if (active_win !== 2'd1 || rd_e_addr !== 23'h1003C)
            $display("FAIL attick_apply: got win %0d e %0h want 1 1003c", active_win, rd_e_addr); else n_pass++;
        frame_stats(rd, fh, fv, lo, rise, bf);
        n_chk++; if (rd !== 60 || rise !== 16) $display("FAIL attick_frame: got cnt %0d rise %0d want 60 16", rd, rise); else n_pass++;
    endtask

    task automatic test_rst_mid_switch();
        int rhi, rd, fh, fv, lo, rise, bf;
        step_n(100);
        next_req = 1'b1;
        step();
        run_to_tick(rhi);
        n_chk++; if (active_win !== 2'd2 || sdram_rst_n !== 1'b0)
            $display("FAIL rstmid_start: got win %0d rst_n %b want 2 0", active_win, sdram_rst_n); else n_pass++;
        step_n(4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_chk++; if (sdram_rden !== 1'b0 || sdram_rst_n !== 1'b0 || switch_busy !== 1'b1)
            $display("FAIL rstmid_ctl: got rden %b rst_n %b busy %b want 0 0 1", sdram_rden, sdram_rst_n, switch_busy);
        else n_pass++;
        n_chk++; if (rd_b_addr !== '0 || rd_e_addr !== '0 || active_win !== 2'd0)
            $display("FAIL rstmid_regs: got b %0h e %0h win %0d want 0 0 0", rd_b_addr, rd_e_addr, active_win);
        else n_pass++;
        run_to_tick(rhi);
        n_chk++; if (rhi !== 0) $display("FAIL rstmid_init_hold: got %0d high cycles want 0", rhi); else n_pass++;
        n_chk++; if (active_win !== 2'd0 || rd_e_addr !== 23'd40)
            $display("FAIL rstmid_reload: got win %0d e %0d want 0 40", active_win, rd_e_addr); else n_pass++;
        frame_stats(rd, fh, fv, lo, rise, bf);
        n_chk++; if (rd !== 40 || rise !== 16) $display("FAIL rstmid_frame: got cnt %0d rise %0d want 40 16", rd, rise); else n_pass++;
    endtask

    initial begin
        rst      = 1'b1;
        hcnt     = '0;
        vcnt     = '0;
        sel_req  = 1'b0;
        sel_idx  = 2'd0;
        next_req = 1'b0;
        win_x    = {12'd2, 12'd4,  12'd0};
        win_y    = {12'd1, 12'd2,  12'd0};
        win_w    = {12'd3, 12'd10, 12'd8};
        win_h    = {12'd4, 12'd6,  12'd5};
        win_base = {23'h20000, 23'h10000, 23'h0};
        #2;
        test_reset();
        test_init_release();
        test_next_req();
        test_wrap();
        test_ignored();
        test_priority();
        test_req_at_tick();
        test_rst_mid_switch();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of run, want summary");
        $fatal(1, "watchdog expired");
    end

endmodule
